// File: rtl/codificador_instrucciones_pkg.sv
// Shared definitions for the instruction encoder and the control unit.
// Holds the instruction-class enumeration, the 6-bit opcode constants
// and the encoder FSM state type.
package codificador_instrucciones_pkg;

  // Instruction class presented on the request interface; 9..15 are unsupported.
  typedef enum logic [3:0] {
    KIND_R    = 4'd0,
    KIND_ADDI = 4'd1,
    KIND_ANDI = 4'd2,
    KIND_ORI  = 4'd3,
    KIND_SLTI = 4'd4,
    KIND_LW   = 4'd5,
    KIND_SW   = 4'd6,
    KIND_BEQ  = 4'd7,
    KIND_J    = 4'd8
  } kind_e;

  // Primary opcodes (instruction bits 31:26).
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;

  // Write-side state: accepting requests, or memory exhausted until clear/rst.
  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_FULL = 1'b1
  } state_e;

endpackage

// File: rtl/codificador_instrucciones_palabra.sv
// codificador_palabra: purely combinational instruction-word encoder.
// Ports:
//   i_kind       instruction class (see kind_e)
//   i_rs/i_rt/i_rd, i_funct, i_imm, i_target   instruction fields
//   o_word       encoded 32-bit instruction (zero for unsupported kinds)
//   o_kind_ok    1 when i_kind is a supported class
module codificador_palabra
  import codificador_instrucciones_pkg::*;
(
  input  logic [3:0]  i_kind,
  input  logic [4:0]  i_rs,
  input  logic [4:0]  i_rt,
  input  logic [4:0]  i_rd,
  input  logic [5:0]  i_funct,
  input  logic [15:0] i_imm,
  input  logic [25:0] i_target,
  output logic [31:0] o_word,
  output logic        o_kind_ok
);

  // Select the field layout from the instruction class.
  always_comb begin
    o_word    = 32'h0000_0000;
    o_kind_ok = 1'b0;
    case (i_kind)
      KIND_R: begin
        o_word    = {OP_R, i_rs, i_rt, i_rd, 5'b00000, i_funct};
        o_kind_ok = 1'b1;
      end
      KIND_ADDI: begin
        o_word    = {OP_ADDI, i_rs, i_rt, i_imm};
        o_kind_ok = 1'b1;
      end
      KIND_ANDI: begin
        o_word    = {OP_ANDI, i_rs, i_rt, i_imm};
        o_kind_ok = 1'b1;
      end
      KIND_ORI: begin
        o_word    = {OP_ORI, i_rs, i_rt, i_imm};
        o_kind_ok = 1'b1;
      end
      KIND_SLTI: begin
        o_word    = {OP_SLTI, i_rs, i_rt, i_imm};
        o_kind_ok = 1'b1;
      end
      KIND_LW: begin
        o_word    = {OP_LW, i_rs, i_rt, i_imm};
        o_kind_ok = 1'b1;
      end
      KIND_SW: begin
        o_word    = {OP_SW, i_rs, i_rt, i_imm};
        o_kind_ok = 1'b1;
      end
      KIND_BEQ: begin
        o_word    = {OP_BEQ, i_rs, i_rt, i_imm};
        o_kind_ok = 1'b1;
      end
      KIND_J: begin
        o_word    = {OP_J, i_target};
        o_kind_ok = 1'b1;
      end
      default: begin
        o_word    = 32'h0000_0000;
        o_kind_ok = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/codificador_instrucciones.sv
// codificador_instrucciones: accepts instruction requests, encodes them and
// writes them sequentially into an instruction memory starting at BASE.
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   clear           restart the write pointer at BASE (next cycle)
//   in_valid/in_ready  request handshake
//   kind, rs, rt, rd, funct, imm, target   request fields
//   mem_we, mem_addr, mem_wdata   registered memory write port
//   full            memory exhausted (2^ADDR_W words written)
//   err             one-cycle pulse for an unsupported kind
//   count           words written since reset or clear
module codificador_instrucciones
  import codificador_instrucciones_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int BASE   = 0
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        kind,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [5:0]        funct,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              full,
  output logic              err,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W-1:0] LP_BASE       = ADDR_W'(BASE);
  localparam logic [ADDR_W-1:0] LP_PTR_ONE    = ADDR_W'(1);
  localparam logic [ADDR_W:0]   LP_CNT_ONE    = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   LP_CNT_ZERO   = (ADDR_W+1)'(0);
  // Count value just before the final word that fills the memory.
  localparam logic [ADDR_W:0]   LP_LAST_COUNT = {1'b0, {ADDR_W{1'b1}}};

  state_e              r_state;
  state_e              w_state_nxt;
  logic [ADDR_W-1:0]   r_ptr;
  logic [ADDR_W:0]     r_count;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [31:0]         r_mem_wdata;
  logic                r_err;

  logic [31:0]         w_word;
  logic                w_kind_ok;
  logic                w_in_ready;
  logic                w_full;
  logic                w_accept;
  logic                w_write;
  logic                w_reject;
  logic                w_last_write;

  codificador_palabra u_palabra (
    .i_kind    (kind),
    .i_rs      (rs),
    .i_rt      (rt),
    .i_rd      (rd),
    .i_funct   (funct),
    .i_imm     (imm),
    .i_target  (target),
    .o_word    (w_word),
    .o_kind_ok (w_kind_ok)
  );

  // An accepted request either becomes a write or an error pulse, never both.
  assign w_accept     = in_valid & w_in_ready;
  assign w_write      = w_accept & w_kind_ok;
  assign w_reject     = w_accept & ~w_kind_ok;
  assign w_last_write = w_write & (r_count == LP_LAST_COUNT);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_RUN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic: clear always returns to RUN and wins over a write.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN: begin
        if (clear) begin
          w_state_nxt = ST_RUN;
        end else if (w_last_write) begin
          w_state_nxt = ST_FULL;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_FULL: begin
        if (clear) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_FULL;
        end
      end
      default: begin
        w_state_nxt = ST_RUN;
      end
    endcase
  end

  // FSM outputs: ready is withheld during rst and clear so neither can race a request.
  always_comb begin
    w_full     = 1'b0;
    w_in_ready = 1'b0;
    case (r_state)
      ST_RUN: begin
        w_full     = 1'b0;
        w_in_ready = ~clear & ~rst;
      end
      ST_FULL: begin
        w_full     = 1'b1;
        w_in_ready = 1'b0;
      end
      default: begin
        w_full     = 1'b0;
        w_in_ready = 1'b0;
      end
    endcase
  end

  // Write pointer and word counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr   <= LP_BASE;
      r_count <= LP_CNT_ZERO;
    end else if (clear) begin
      r_ptr   <= LP_BASE;
      r_count <= LP_CNT_ZERO;
    end else if (w_write) begin
      r_ptr   <= r_ptr + LP_PTR_ONE;
      r_count <= r_count + LP_CNT_ONE;
    end else begin
      r_ptr   <= r_ptr;
      r_count <= r_count;
    end
  end

  // Registered memory port and error pulse; address/data hold between writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mem_we    <= 1'b0;
      r_mem_addr  <= LP_BASE;
      r_mem_wdata <= 32'h0000_0000;
      r_err       <= 1'b0;
    end else begin
      r_mem_we <= w_write;
      r_err    <= w_reject;
      if (w_write) begin
        r_mem_addr  <= r_ptr;
        r_mem_wdata <= w_word;
      end else begin
        r_mem_addr  <= r_mem_addr;
        r_mem_wdata <= r_mem_wdata;
      end
    end
  end

  assign in_ready  = w_in_ready;
  assign full      = w_full;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign err       = r_err;
  assign count     = r_count;

endmodule

// File: doc/codificador_instrucciones.md
CODIFICADOR_INSTRUCCIONES -- requirements
Module: codificador_instrucciones

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, instruction-memory word-address width.
REQ-002 SHALL have parameter BASE, default 0, first word address written after reset or clear.
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 Port list (name, direction, width, meaning):
- clk  in  1  sole clock, rising edge
- rst  in  1  synchronous, active-high reset
- clear  in  1  restart write pointer at BASE
- in_valid  in  1  request valid
- in_ready  out  1  block can accept a request
- kind  in  4  instruction class: 0 R, 1 ADDI, 2 ANDI, 3 ORI, 4 SLTI, 5 LW, 6 SW, 7 BEQ, 8 J
- rs, rt, rd  in  5 each  register fields
- funct  in  6  R-type function code
- imm  in  16  I-type immediate
- target  in  26  J-type target
- mem_we  out  1  instruction-memory write strobe
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  32  encoded instruction word
- full  out  1  instruction memory full
- err  out  1  one-cycle pulse on an unsupported kind
- count  out  ADDR_W+1  words written since reset or clear

Function
REQ-005 Transfer SHALL occur only when in_valid=1 and in_ready=1 on a rising edge of clk.
REQ-006 in_ready SHALL be 1 only when state is RUN and clear=0.
REQ-007 Accepting a request SHALL take one cycle of latency: on the next cycle mem_we=1, mem_addr=ptr and mem_wdata=encoded word, all registered.
REQ-008 R encoding SHALL be {6'b000000, rs, rt, rd, 5'b00000, funct}.
REQ-009 I encoding SHALL be {op, rs, rt, imm} with op: ADDI 001000, ANDI 001100, ORI 001101, SLTI 001010, LW 100011, SW 101011, BEQ 000100.
REQ-010 J encoding SHALL be {6'b000010, target}.
REQ-011 A kind value of 9..15 SHALL cause the following:
- err pulses high for one cycle, latency as in REQ-007.
- mem_we stays 0.
- ptr and count are unchanged.
REQ-012 Each write SHALL do the following:
- increment ptr modulo 2^ADDR_W.
- increment count.
REQ-013 State machine SHALL have two states, RUN and FULL:
- RUN to FULL when a write occurs with count reaching 2^ADDR_W.
- FULL to RUN only on clear or rst.
REQ-014 In state FULL, the following SHALL hold:
- full=1 and in_ready=0.
- in_valid is ignored.
- no further writes or err pulses occur.
REQ-015 clear=1 SHALL take effect on the next cycle:
- ptr=BASE, count=0, state RUN.
- clear has priority over a simultaneous request, which is not accepted because in_ready=0.
- a write already registered from the previous cycle still completes.
REQ-016 mem_we and err SHALL never be 1 in the same cycle.
REQ-017 mem_wdata and mem_addr SHALL hold their last values when mem_we=0.

Reset
REQ-018 On rst=1 at a clock edge, the block SHALL set the following, overriding clear and any handshake:
- state RUN.
- ptr=BASE, count=0.
- mem_we=0, mem_addr=BASE, mem_wdata=0.
- err=0, full=0.
REQ-019 rst asserted mid-operation SHALL drop any pending registered write: no mem_we in the cycle after rst.
REQ-020 in_ready SHALL be 0 while rst=1 and SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-021 A shared package SHALL hold the kind enumeration and the 6-bit opcode constants (R 000000, J 000010 and the I-type values), common with the control unit.
REQ-022 The combinational word encoder SHALL be one sub-module, codificador_palabra (kind and fields in; 32-bit word and a valid-kind flag out); the remaining logic stays in the top module.

Verification
REQ-023 The bench SHALL cover the following directed scenarios:
- After reset, R request with rs=1, rt=2, rd=3, funct=0x20 -> next cycle mem_we=1, mem_addr=0, mem_wdata=0x00221820, count=1.
- Back-to-back ADDI (rs=1, rt=2, imm=5), LW (rs=0, rt=8, imm=4) and J (target=0x10) -> data 0x20220005, 0x8C080004, 0x08000010 at addresses 0, 1, 2 on consecutive cycles.
- kind=12 -> err pulses one cycle, no mem_we, count unchanged.
- ADDR_W=2, five requests -> four writes to addresses 0..3; full=1 and in_ready=0 after the fourth; fifth request not accepted.
- clear together with in_valid while full -> request not accepted; next cycle full=0, count=0; next write goes to BASE.
- rst in the cycle after an accept -> no mem_we; all outputs at reset values.
